// File: rtl/micro_sequencer_if.sv
// Bundle of sequencer inputs (instruction fields, memory handshake) and
// outputs (microstate address, status pulses, cycle counters).
// Handshake: mem_ready is sampled in Fetch/MemRead/MemWrite only; when the
// memory wait is enabled and mem_ready=0 the sequencer stays in that state
// for the cycle, and the access completes in the cycle mem_ready=1 is seen.
interface micro_sequencer_if #(
  parameter int CYC_W = 4
);
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             mem_ready;
  logic [3:0]       adr;
  logic             instr_done;
  logic             illegal;
  logic [CYC_W-1:0] last_cycles;
  logic [CYC_W-1:0] stall_count;
  // Latched instruction fields, visible for checkers
  logic [1:0]       dbg_op;
  logic [5:0]       dbg_funct;

  modport master (
    output Op, Funct, mem_ready,
    input  adr, instr_done, illegal, last_cycles, stall_count, dbg_op, dbg_funct
  );

  modport slave (
    input  Op, Funct, mem_ready,
    output adr, instr_done, illegal, last_cycles, stall_count, dbg_op, dbg_funct
  );
endinterface

// File: rtl/micro_sequencer.sv
// Next-address generator for the multicycle microprogrammed controller.
// Holds the microstate (which is also the control-memory address), picks the
// next state from Op/Funct and memory wait states, and reports instruction
// retirement, illegal opcodes, instruction cycle counts and wait counts.
module micro_sequencer #(
  parameter bit MEM_WAIT = 1'b1,
  parameter int CYC_W    = 4
) (
  input logic              clk,
  input logic              reset,
  micro_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [CYC_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);

  state_t           state, next_state;
  logic [1:0]       op_q;
  logic [5:0]       funct_q;
  logic [CYC_W-1:0] cyc_cnt;      // cycles finished so far in this instruction
  logic [CYC_W-1:0] cyc_now;      // count including the current cycle
  logic [CYC_W-1:0] stall_q;
  logic [CYC_W-1:0] last_q;
  logic             mem_wait;
  logic             stall_cyc;
  logic             ill_dec;
  logic             retire;
  logic             leave;

  assign mem_wait = MEM_WAIT && !bus.mem_ready;
  assign cyc_now  = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CNT_ONE;

  // Next-state decode, wait detection and illegal-opcode detection
  always_comb begin
    next_state = S_FETCH;
    stall_cyc  = 1'b0;
    ill_dec    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_wait) begin
          next_state = S_FETCH;
          stall_cyc  = 1'b1;
        end else begin
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.Op)
          2'b01:   next_state = S_MEMADR;
          2'b00:   next_state = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   next_state = S_BRANCH;
          default: begin
            next_state = S_FETCH;
            ill_dec    = 1'b1;
          end
        endcase
      end
      // Uses the L bit captured in Decode, not the live Funct input
      S_MEMADR:  next_state = funct_q[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_wait) begin
          next_state = S_MEMREAD;
          stall_cyc  = 1'b1;
        end else begin
          next_state = S_MEMWB;
        end
      end
      S_MEMWRITE: begin
        if (mem_wait) begin
          next_state = S_MEMWRITE;
          stall_cyc  = 1'b1;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_EXECR, S_EXECI:          next_state = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: next_state = S_FETCH;
      default:                   next_state = S_FETCH;
    endcase
  end

  // Leaving any non-Fetch state into Fetch ends the instruction; only the
  // genuine final states count as a retirement (not illegal or bad codes).
  assign leave  = (state != S_FETCH) && (next_state == S_FETCH);
  assign retire = !reset && (next_state == S_FETCH) &&
                  ((state == S_MEMWRITE) || (state == S_MEMWB) ||
                   (state == S_ALUWB) || (state == S_BRANCH));

  // State register, field latches and cycle/stall counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      funct_q <= '0;
      cyc_cnt <= '0;
      stall_q <= '0;
      last_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q    <= bus.Op;
        funct_q <= bus.Funct;
      end
      if (leave) begin
        cyc_cnt <= '0;
        stall_q <= '0;
      end else begin
        cyc_cnt <= cyc_now;
        if (stall_cyc && (stall_q != CNT_MAX)) begin
          stall_q <= stall_q + CNT_ONE;
        end
      end
      if (retire) begin
        last_q <= cyc_now;
      end
    end
  end

  assign bus.adr         = state;
  assign bus.instr_done  = retire;
  assign bus.illegal     = ill_dec && !reset;
  assign bus.last_cycles = last_q;
  assign bus.stall_count = stall_q;
  assign bus.dbg_op      = op_q;
  assign bus.dbg_funct   = funct_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: one instance with memory waits enabled and one
// with them disabled, both driven from a per-cycle vector table. Each row's
// expected outputs go into exp_q when the row is driven and are popped and
// compared at the following falling edge.
module tb_micro_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  micro_sequencer_if #(.CYC_W(4)) bus0 ();
  micro_sequencer_if #(.CYC_W(4)) bus1 ();

  micro_sequencer #(.MEM_WAIT(1'b0), .CYC_W(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  micro_sequencer #(.MEM_WAIT(1'b1), .CYC_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // clock/reset
  always #5 clk = ~clk;

  // sel: 0 = check no-wait instance, 1 = check wait instance, 2 = drive only
  typedef struct {
    int         sel;
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mr;
    logic [3:0] adr;
    logic       done;
    logic       ill;
    logic [3:0] last;
    logic [3:0] stall;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic add(input int sel, input logic rst, input logic [1:0] op,
                     input logic [5:0] funct, input logic mr,
                     input logic [3:0] adr, input logic done, input logic ill,
                     input logic [3:0] last, input logic [3:0] stall);
    vec_t v;
    v.sel = sel; v.rst = rst; v.op = op; v.funct = funct; v.mr = mr;
    v.adr = adr; v.done = done; v.ill = ill; v.last = last; v.stall = stall;
    vecs.push_back(v);
  endtask

  // driver: apply one row, starting just after a rising edge
  task automatic drive_row(input vec_t v);
    reset          = v.rst;
    bus0.Op        = v.op;
    bus1.Op        = v.op;
    bus0.Funct     = v.funct;
    bus1.Funct     = v.funct;
    bus0.mem_ready = v.mr;
    bus1.mem_ready = v.mr;
    if (v.sel != 2) exp_q.push_back({v.adr, v.done, v.ill, v.last, v.stall});
  endtask

  // scoreboard: pop the expectation for this row and compare
  task automatic check_row(input int idx, input int sel);
    logic [13:0] e;
    logic [13:0] a;
    if (sel == 2) return;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL row%0d: expected queue empty", idx);
      return;
    end
    e = exp_q.pop_front();
    if (sel == 0)
      a = {bus0.adr, bus0.instr_done, bus0.illegal, bus0.last_cycles, bus0.stall_count};
    else
      a = {bus1.adr, bus1.instr_done, bus1.illegal, bus1.last_cycles, bus1.stall_count};
    n_checks++;
    if (a === e) begin
      n_pass++;
    end else begin
      $display("FAIL row%0d dut%0d: got adr=%0d done=%b ill=%b last=%0d stall=%0d, want adr=%0d done=%b ill=%b last=%0d stall=%0d",
               idx, sel, a[13:10], a[9], a[8], a[7:4], a[3:0],
               e[13:10], e[9], e[8], e[7:4], e[3:0]);
    end
  endtask

  initial begin
    bus0.Op = 2'b00; bus1.Op = 2'b00;
    bus0.Funct = 6'h00; bus1.Funct = 6'h00;
    bus0.mem_ready = 1'b1; bus1.mem_ready = 1'b1;

    // reset for two cycles, then reset state
    add(2, 1, 2'd0, 6'h00, 1, 0, 0, 0, 0, 0);
    add(2, 1, 2'd0, 6'h00, 1, 0, 0, 0, 0, 0);
    // LDR, no waits: 0,1,2,3,5 -> 5 cycles
    add(1, 0, 2'd1, 6'h01, 1, 0, 0, 0, 0, 0);
    add(1, 0, 2'd1, 6'h01, 1, 1, 0, 0, 0, 0);
    add(1, 0, 2'd1, 6'h01, 1, 2, 0, 0, 0, 0);
    add(1, 0, 2'd1, 6'h01, 1, 3, 0, 0, 0, 0);
    add(1, 0, 2'd1, 6'h01, 1, 5, 1, 0, 0, 0);
    // DP immediate: 0,1,7,8 -> 4 cycles
    add(1, 0, 2'd0, 6'h20, 1, 0, 0, 0, 5, 0);
    add(1, 0, 2'd0, 6'h20, 1, 1, 0, 0, 5, 0);
    add(1, 0, 2'd0, 6'h20, 1, 7, 0, 0, 5, 0);
    add(1, 0, 2'd0, 6'h20, 1, 8, 1, 0, 5, 0);
    // Branch: 0,1,9 -> 3 cycles
    add(1, 0, 2'd2, 6'h00, 1, 0, 0, 0, 4, 0);
    add(1, 0, 2'd2, 6'h00, 1, 1, 0, 0, 4, 0);
    add(1, 0, 2'd2, 6'h00, 1, 9, 1, 0, 4, 0);
    // STR with three wait cycles in MemWrite -> 7 cycles
    add(1, 0, 2'd1, 6'h00, 1, 0, 0, 0, 3, 0);
    add(1, 0, 2'd1, 6'h00, 1, 1, 0, 0, 3, 0);
    add(1, 0, 2'd1, 6'h00, 1, 2, 0, 0, 3, 0);
    add(1, 0, 2'd1, 6'h00, 0, 4, 0, 0, 3, 0);
    add(1, 0, 2'd1, 6'h00, 0, 4, 0, 0, 3, 1);
    add(1, 0, 2'd1, 6'h00, 0, 4, 0, 0, 3, 2);
    add(1, 0, 2'd1, 6'h00, 1, 4, 1, 0, 3, 3);
    // Illegal opcode: pulse in Decode, back to Fetch, last unchanged
    add(1, 0, 2'd3, 6'h00, 1, 0, 0, 0, 7, 0);
    add(1, 0, 2'd3, 6'h00, 1, 1, 0, 1, 7, 0);
    // L latched as 0, live Funct[0] goes to 1 in MemAdr -> MemWrite
    add(1, 0, 2'd1, 6'h00, 1, 0, 0, 0, 7, 0);
    add(1, 0, 2'd1, 6'h00, 1, 1, 0, 0, 7, 0);
    add(1, 0, 2'd1, 6'h01, 1, 2, 0, 0, 7, 0);
    add(1, 0, 2'd1, 6'h01, 1, 4, 1, 0, 7, 0);
    // DP register: 0,1,6,8 -> 4 cycles
    add(1, 0, 2'd0, 6'h00, 1, 0, 0, 0, 4, 0);
    add(1, 0, 2'd0, 6'h00, 1, 1, 0, 0, 4, 0);
    add(1, 0, 2'd0, 6'h00, 1, 6, 0, 0, 4, 0);
    add(1, 0, 2'd0, 6'h00, 1, 8, 1, 0, 4, 0);
    // Branch with two Fetch wait cycles -> 5 cycles, stall 2
    add(1, 0, 2'd2, 6'h00, 0, 0, 0, 0, 4, 0);
    add(1, 0, 2'd2, 6'h00, 0, 0, 0, 0, 4, 1);
    add(1, 0, 2'd2, 6'h00, 1, 0, 0, 0, 4, 2);
    add(1, 0, 2'd2, 6'h00, 1, 1, 0, 0, 4, 2);
    add(1, 0, 2'd2, 6'h00, 1, 9, 1, 0, 4, 2);
    // LDR aborted by two reset cycles while waiting in MemRead
    add(1, 0, 2'd1, 6'h01, 1, 0, 0, 0, 5, 0);
    add(1, 0, 2'd1, 6'h01, 1, 1, 0, 0, 5, 0);
    add(1, 0, 2'd1, 6'h01, 1, 2, 0, 0, 5, 0);
    add(1, 0, 2'd1, 6'h01, 0, 3, 0, 0, 5, 0);
    add(1, 1, 2'd1, 6'h01, 1, 3, 0, 0, 5, 1);
    add(1, 1, 2'd1, 6'h01, 1, 0, 0, 0, 0, 0);
    // Long Fetch wait: stall and cycle counters saturate at 15
    for (int i = 0; i < 21; i++) begin
      add(1, 0, 2'd1, 6'h01, (i == 20), 0, 0, 0, 0, 4'((i > 15) ? 15 : i));
    end
    add(1, 0, 2'd1, 6'h01, 1, 1, 0, 0, 0, 15);
    add(1, 0, 2'd1, 6'h01, 1, 2, 0, 0, 0, 15);
    add(1, 0, 2'd1, 6'h01, 1, 3, 0, 0, 0, 15);
    add(1, 0, 2'd1, 6'h01, 1, 5, 1, 0, 0, 15);
    add(1, 0, 2'd2, 6'h00, 1, 0, 0, 0, 15, 0);
    // No-wait instance: LDR with mem_ready held low throughout
    add(2, 1, 2'd1, 6'h01, 0, 0, 0, 0, 0, 0);
    add(2, 1, 2'd1, 6'h01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2'd1, 6'h01, 0, 0, 0, 0, 0, 0);
    add(0, 0, 2'd1, 6'h01, 0, 1, 0, 0, 0, 0);
    add(0, 0, 2'd1, 6'h01, 0, 2, 0, 0, 0, 0);
    add(0, 0, 2'd1, 6'h01, 0, 3, 0, 0, 0, 0);
    add(0, 0, 2'd1, 6'h01, 0, 5, 1, 0, 0, 0);
    add(0, 0, 2'd0, 6'h00, 0, 0, 0, 0, 5, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive_row(vecs[i]);
      @(negedge clk);
      check_row(i, vecs[i].sel);
      @(posedge clk); #1;
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
